layers_feed: RTL and testbench

Image-stream transmitter that sources the `image_bus` / `image_last` / `image_val` / `image_rdy` input of the layers block. It pulls group-wide image words from an upstream buffer FIFO and frames them into MAC windows of a configured length, with `image_last` on the final beat of each window. It also emits the in-window kernel address used to fetch the matching `kernel_bus` word. It sits between the image buffer and layers, and is configured over the shared cfg bus.

---
 rtl/layers_feed.sv | 261 ++++++++++++++++++++++++++
 tb/tb_layers_feed.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/layers_feed.sv
// layers_feed: frames group-wide image words from an upstream FIFO into MAC
// windows for the layers block, tagging the final beat of each window with
// image_last and emitting the in-window kernel address.
// Optional build macro: LAYERS_FEED_STATS_EN enables the downstream stall
// counter on stall_cnt; without it stall_cnt is tied to zero.
module layers_feed #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int CFG_ADDR    = 6,
  parameter int GROUP_NB    = 4,
  parameter int IMG_WIDTH   = 16,
  parameter int KADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] src_bus,
  input  logic                          src_val,
  output logic                          src_rdy,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy,
  output logic [KADDR_WIDTH-1:0]        ker_addr,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   stall_cnt
);

  localparam int DW = GROUP_NB * IMG_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Run configuration
  logic [15:0] r_win_len;
  logic [15:0] r_win_nb;

  // Upstream tagging counters
  logic [15:0] r_up_beat;
  logic [15:0] r_up_win;
  logic        r_up_done;

  // Downstream counters
  logic [15:0]            r_win_cnt;
  logic [KADDR_WIDTH-1:0] r_ker_addr;

  // Two-entry skid buffer, slot 0 is the head
  logic [DW-1:0] r_data0;
  logic [DW-1:0] r_data1;
  logic          r_last0;
  logic          r_last1;
  logic [1:0]    r_cnt;
  logic          r_src_rdy;

  logic        w_start;
  logic [15:0] w_cfg_len;
  logic [15:0] w_cfg_nb;
  logic        w_push;
  logic        w_pop;
  logic        w_pop_last;
  logic        w_final;
  logic        w_up_last;
  logic        w_up_final;
  logic        w_up_done_next;
  logic [1:0]  w_cnt_next;

  assign w_cfg_len  = cfg_data[15:0];
  assign w_cfg_nb   = cfg_data[31:16];
  assign w_start    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_ADDR)) && (r_state == S_IDLE);

  assign w_push     = src_val & r_src_rdy;
  assign w_pop      = (r_cnt != 2'd0) & image_rdy;
  assign w_pop_last = w_pop & r_last0;
  assign w_final    = w_pop_last && (r_win_cnt == r_win_nb - 16'd1);

  assign w_up_last      = (r_up_beat == r_win_len - 16'd1);
  assign w_up_final     = w_push && w_up_last && (r_up_win == r_win_nb - 16'd1);
  assign w_up_done_next = w_start ? 1'b0 : (r_up_done | w_up_final);

  // Buffer occupancy after this cycle's transfers
  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_cnt + 2'd1;
      2'b01:   w_cnt_next = r_cnt - 2'd1;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if ((w_cfg_len != 16'd0) && (w_cfg_nb != 16'd0)) w_state_next = S_RUN;
          else                                             w_state_next = S_DONE;
        end
      end
      S_RUN:   if (w_final) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Latch window geometry on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_len <= '0;
      r_win_nb  <= '0;
    end else if (w_start) begin
      r_win_len <= w_cfg_len;
      r_win_nb  <= w_cfg_nb;
    end
  end

  // Upstream beat/window tagging; stops accepting after the final word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up_beat <= '0;
      r_up_win  <= '0;
      r_up_done <= 1'b0;
    end else if (w_start) begin
      r_up_beat <= '0;
      r_up_win  <= '0;
      r_up_done <= 1'b0;
    end else begin
      r_up_done <= w_up_done_next;
      if (w_push) begin
        if (w_up_last) begin
          r_up_beat <= '0;
          r_up_win  <= r_up_win + 16'd1;
        end else begin
          r_up_beat <= r_up_beat + 16'd1;
        end
      end
    end
  end

  // Registered upstream ready: open only while the buffer keeps a free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_src_rdy <= 1'b0;
    else     r_src_rdy <= (w_state_next == S_RUN) && (w_cnt_next <= 2'd1) && !w_up_done_next;
  end

  // Skid buffer: push to first free slot, pop shifts slot 1 into the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_cnt <= w_cnt_next;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_data0 <= src_bus;
            r_last0 <= w_up_last;
          end else begin
            r_data1 <= src_bus;
            r_last1 <= w_up_last;
          end
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_data0 <= src_bus;
            r_last0 <= w_up_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= src_bus;
            r_last1 <= w_up_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Downstream kernel address and window count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ker_addr <= '0;
      r_win_cnt  <= '0;
    end else if (w_start) begin
      r_ker_addr <= '0;
      r_win_cnt  <= '0;
    end else if (w_pop) begin
      if (r_last0) begin
        r_ker_addr <= '0;
        r_win_cnt  <= r_win_cnt + 16'd1;
      end else begin
        r_ker_addr <= r_ker_addr + KADDR_WIDTH'(1);
      end
    end
  end

  assign src_rdy    = r_src_rdy;
  assign image_bus  = r_data0;
  assign image_last = r_last0;
  assign image_val  = (r_cnt != 2'd0);
  assign ker_addr   = r_ker_addr;

`ifdef LAYERS_FEED_STATS_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where layers back-pressures a valid beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if (busy && image_val && !image_rdy && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_layers_feed.sv
// Directed testbench for layers_feed: a bench-side upstream FIFO model feeds
// numbered words; every valid downstream beat is compared with the expected
// word, last flag and kernel address.
module tb_layers_feed;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic [63:0] src_bus;
  logic        src_val;
  logic        src_rdy;
  logic [63:0] image_bus;
  logic        image_last;
  logic        image_val;
  logic        image_rdy;
  logic [15:0] ker_addr;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int src_idx = 0;
  int exp_idx = 0;
  int cyc;

  layers_feed #(
    .CFG_DWIDTH (32),
    .CFG_AWIDTH (5),
    .CFG_ADDR   (6),
    .GROUP_NB   (4),
    .IMG_WIDTH  (16),
    .KADDR_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_valid (cfg_valid),
    .src_bus   (src_bus),
    .src_val   (src_val),
    .src_rdy   (src_rdy),
    .image_bus (image_bus),
    .image_last(image_last),
    .image_val (image_val),
    .image_rdy (image_rdy),
    .ker_addr  (ker_addr),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int i);
    return {16'hA000 + 16'(i), 16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the upstream model advances on an accepted word
  task automatic cycle();
    logic p;
    p = src_val & src_rdy;
    @(posedge clk);
    @(negedge clk);
    if (p) begin
      src_idx++;
      src_bus = mk(src_idx);
    end
  endtask

  task automatic start(input int len, input int nb);
    cfg_addr  = 5'd6;
    cfg_data  = {16'(nb), 16'(len)};
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  // Consume nbeats beats, holding image_rdy low on iterations st_lo..st_hi
  task automatic run(input int len, input int nbeats, input int st_lo, input int st_hi,
                     output int n);
    int k = 0;
    int beats = 0;
    n = 0;
    while (beats < nbeats && n < 200) begin
      n++;
      image_rdy = !(n >= st_lo && n <= st_hi);
      if (image_val) begin
        chk("data", image_bus, mk(exp_idx));
        chk("last", 64'(image_last), 64'(k == len - 1));
        chk("ker_addr", 64'(ker_addr), 64'(k));
      end
      if (image_val && image_rdy) begin
        exp_idx++;
        beats++;
        k = (k == len - 1) ? 0 : k + 1;
      end
      cycle();
    end
    image_rdy = 1'b1;
    chk("beat_count", 64'(beats), 64'(nbeats));
  endtask

  task automatic chk_done_pulse();
    chk("done_hi", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("val_after_run", 64'(image_val), 64'd0);
    cycle();
    chk("done_lo", 64'(done), 64'd0);
    chk("busy_lo", 64'(busy), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_data  = '0;
    cfg_addr  = '0;
    cfg_valid = 1'b0;
    src_val   = 1'b1;
    src_bus   = mk(0);
    image_rdy = 1'b1;
    #2;
    chk("rst_src_rdy", 64'(src_rdy), 64'd0);
    chk("rst_image_bus", image_bus, 64'd0);
    chk("rst_image_last", 64'(image_last), 64'd0);
    chk("rst_image_val", 64'(image_val), 64'd0);
    chk("rst_ker_addr", 64'(ker_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Two windows of four beats, no back-pressure
    start(4, 2);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_src_rdy", 64'(src_rdy), 64'd1);
    chk("t1_val0", 64'(image_val), 64'd0);
    run(4, 8, 0, -1, cyc);
    chk("t1_cycles", 64'(cyc), 64'd9);
    chk_done_pulse();

    // One window of three with layers stalling on iterations 2..4
    start(3, 1);
    run(3, 3, 2, 4, cyc);
    chk("t2_cycles", 64'(cyc), 64'd7);
`ifdef LAYERS_FEED_STATS_EN
    chk("t2_stall", 64'(stall_cnt), 64'd3);
`else
    chk("t2_stall", 64'(stall_cnt), 64'd0);
`endif
    chk_done_pulse();

    // Single-beat windows
    start(1, 3);
    run(1, 3, 0, -1, cyc);
    chk_done_pulse();

    // Zero window count: straight to DONE, nothing issued
    start(4, 0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_val", 64'(image_val), 64'd0);
    chk("t4_src_rdy", 64'(src_rdy), 64'd0);
    cycle();
    chk("t4_done_lo", 64'(done), 64'd0);
    chk("t4_busy_lo", 64'(busy), 64'd0);
    cycle();
    chk("t4_val_idle", 64'(image_val), 64'd0);

    // Reconfigure attempt during RUN is ignored
    image_rdy = 1'b0;
    start(2, 2);
    start(5, 5);
    image_rdy = 1'b1;
    run(2, 4, 0, -1, cyc);
    chk_done_pulse();
    cycle();
    chk("t5_no_extra", 64'(image_val), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // Asynchronous reset after beat 2 of a 4-beat window
    start(4, 1);
    run(4, 2, 0, -1, cyc);
    rst = 1'b1;
    #1;
    chk("ar_src_rdy", 64'(src_rdy), 64'd0);
    chk("ar_image_bus", image_bus, 64'd0);
    chk("ar_image_last", 64'(image_last), 64'd0);
    chk("ar_image_val", 64'(image_val), 64'd0);
    chk("ar_ker_addr", 64'(ker_addr), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_idx = src_idx;
    cycle();
    chk("ar_no_done", 64'(done), 64'd0);
    start(4, 1);
    run(4, 4, 0, -1, cyc);
    chk_done_pulse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
